// File: rtl/clock_pkg.sv
// Shared types, widths, limits and segment patterns for the clock display slice.
package clock_pkg;

  localparam int unsigned SEC_W       = 6;
  localparam int unsigned MIN_W       = 6;
  localparam int unsigned HR_W        = 5;
  localparam int unsigned BIN_W       = 6;
  localparam int unsigned BCD_W       = 8;
  localparam int unsigned NIB_W       = 4;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned SHIFT_STEPS = 6;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;
  localparam int unsigned HR_NOON = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    STORE,
    UPDATE
  } state_t;

  typedef enum logic [1:0] {
    F_SEC,
    F_MIN,
    F_HR
  } field_t;

  // Active-high patterns, bit0 = seg a .. bit6 = seg g
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;

  localparam logic [9:0][SEG_W-1:0] DIGIT_PAT = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Hour value actually converted: 12-hour folding only applies to legal hours
  function automatic logic [BIN_W-1:0] hr_display(input logic [HR_W-1:0] hr,
                                                   input logic            fmt_12h);
    logic [HR_W-1:0] h;
    h = hr;
    if (fmt_12h && (hr <= HR_W'(HR_MAX))) begin
      if (hr == HR_W'(0))            h = HR_W'(HR_NOON);
      else if (hr > HR_W'(HR_NOON))  h = hr - HR_W'(HR_NOON);
    end
    return BIN_W'(h);
  endfunction

endpackage

// File: rtl/clock_display_if.sv
// Time inputs and seven-segment outputs of the clock display.
interface clock_display_if;
  import clock_pkg::*;

  logic [SEC_W-1:0] sec;
  logic [MIN_W-1:0] min;
  logic [HR_W-1:0]  hr;
  logic             fmt_12h;
  logic [SEG_W-1:0] HEX0;
  logic [SEG_W-1:0] HEX1;
  logic [SEG_W-1:0] HEX2;
  logic [SEG_W-1:0] HEX3;
  logic [SEG_W-1:0] HEX4;
  logic [SEG_W-1:0] HEX5;
  logic             pm;
  logic             busy;

  modport master (
    output sec, min, hr, fmt_12h,
    input  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, pm, busy
  );

  modport slave (
    input  sec, min, hr, fmt_12h,
    output HEX0, HEX1, HEX2, HEX3, HEX4, HEX5, pm, busy
  );
endinterface

// File: rtl/seg7_lut.sv
// BCD digit to seven-segment decoder with blank and dash overrides.
module seg7_lut
  import clock_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic [NIB_W-1:0] digit,
  input  logic             blank,
  input  logic             dash,
  output logic [SEG_W-1:0] seg_c
);

  logic [SEG_W-1:0] pat;

  // Codes above 9 fall back to blank so no hex letters can appear
  always_comb begin
    pat = SEG_BLANK;
    if (dash)
      pat = SEG_DASH;
    else if (!blank && (digit <= NIB_W'(9)))
      pat = DIGIT_PAT[digit];
    seg_c = SEG_ACTIVE_LOW ? ~pat : pat;
  end

endmodule

// File: rtl/clock_display.sv
// Binary time-of-day to six seven-segment digits via a shared double-dabble engine.
// Optional: CLOCK_DISPLAY_BLANK_LZ_EN blanks a leading zero on the hours tens digit.
module clock_display
  import clock_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  clock_display_if.slave  bus
);

  localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

  state_t state, state_next;

  logic [SEC_W-1:0] snap_sec;
  logic [MIN_W-1:0] snap_min;
  logic [HR_W-1:0]  snap_hr;
  logic             snap_fmt;
  logic             stale;

  field_t           field;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] bin_q;
  logic [BCD_W-1:0] bcd_q;

  logic [NIB_W-1:0] sec_o, sec_t, min_o, min_t, hr_o, hr_t;
  logic             sec_dash, min_dash, hr_dash;

  logic             changed;
  logic             capture;
  logic [BIN_W-1:0] load_val;
  logic [BCD_W-1:0] bcd_adj;
  logic             hr_tens_blank;
  logic [SEG_W-1:0] seg0, seg1, seg2, seg3, seg4, seg5;

  assign changed = {bus.sec, bus.min, bus.hr, bus.fmt_12h}
                != {snap_sec, snap_min, snap_hr, snap_fmt};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (stale || changed) begin
          capture    = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD:   state_next = SHIFT;
      SHIFT:  if (cnt == CNT_W'(SHIFT_STEPS - 1)) state_next = STORE;
      STORE:  state_next = (field == F_HR) ? UPDATE : LOAD;
      UPDATE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (field)
      F_SEC:   load_val = BIN_W'(snap_sec);
      F_MIN:   load_val = BIN_W'(snap_min);
      default: load_val = hr_display(snap_hr, snap_fmt);
    endcase
  end

  // Add-3 correction applied before each shift
  always_comb begin
    bcd_adj[3:0] = (bcd_q[3:0] >= NIB_W'(5)) ? bcd_q[3:0] + NIB_W'(3) : bcd_q[3:0];
    bcd_adj[7:4] = (bcd_q[7:4] >= NIB_W'(5)) ? bcd_q[7:4] + NIB_W'(3) : bcd_q[7:4];
  end

`ifdef CLOCK_DISPLAY_BLANK_LZ_EN
  assign hr_tens_blank = (hr_t == NIB_W'(0)) && !hr_dash;
`else
  assign hr_tens_blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_sec <= '0;
      snap_min <= '0;
      snap_hr  <= '0;
      snap_fmt <= 1'b0;
      stale    <= 1'b1;
      field    <= F_SEC;
      cnt      <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      sec_o    <= '0;
      sec_t    <= '0;
      min_o    <= '0;
      min_t    <= '0;
      hr_o     <= '0;
      hr_t     <= '0;
      sec_dash <= 1'b0;
      min_dash <= 1'b0;
      hr_dash  <= 1'b0;
      bus.HEX0 <= SEG_OFF;
      bus.HEX1 <= SEG_OFF;
      bus.HEX2 <= SEG_OFF;
      bus.HEX3 <= SEG_OFF;
      bus.HEX4 <= SEG_OFF;
      bus.HEX5 <= SEG_OFF;
      bus.pm   <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.busy <= (state_next != IDLE);
      case (state)
        IDLE: begin
          if (capture) begin
            snap_sec <= bus.sec;
            snap_min <= bus.min;
            snap_hr  <= bus.hr;
            snap_fmt <= bus.fmt_12h;
            stale    <= 1'b0;
            field    <= F_SEC;
          end
        end
        LOAD: begin
          bin_q <= load_val;
          bcd_q <= '0;
          cnt   <= '0;
        end
        SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj, bin_q} << 1;
          cnt            <= cnt + CNT_W'(1);
        end
        STORE: begin
          case (field)
            F_SEC: begin
              sec_o    <= bcd_q[3:0];
              sec_t    <= bcd_q[7:4];
              sec_dash <= (snap_sec > SEC_W'(SEC_MAX));
              field    <= F_MIN;
            end
            F_MIN: begin
              min_o    <= bcd_q[3:0];
              min_t    <= bcd_q[7:4];
              min_dash <= (snap_min > MIN_W'(MIN_MAX));
              field    <= F_HR;
            end
            default: begin
              hr_o     <= bcd_q[3:0];
              hr_t     <= bcd_q[7:4];
              hr_dash  <= (snap_hr > HR_W'(HR_MAX));
              field    <= F_SEC;
            end
          endcase
        end
        UPDATE: begin
          // All digits and pm commit together so the display never tears
          bus.HEX0 <= seg0;
          bus.HEX1 <= seg1;
          bus.HEX2 <= seg2;
          bus.HEX3 <= seg3;
          bus.HEX4 <= seg4;
          bus.HEX5 <= seg5;
          bus.pm   <= snap_fmt && (snap_hr >= HR_W'(HR_NOON));
        end
        default: ;
      endcase
    end
  end

  seg7_lut #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg0 (
    .digit(sec_o), .blank(1'b0), .dash(sec_dash), .seg_c(seg0));
  seg7_lut #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg1 (
    .digit(sec_t), .blank(1'b0), .dash(sec_dash), .seg_c(seg1));
  seg7_lut #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg2 (
    .digit(min_o), .blank(1'b0), .dash(min_dash), .seg_c(seg2));
  seg7_lut #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg3 (
    .digit(min_t), .blank(1'b0), .dash(min_dash), .seg_c(seg3));
  seg7_lut #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg4 (
    .digit(hr_o), .blank(1'b0), .dash(hr_dash), .seg_c(seg4));
  seg7_lut #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg5 (
    .digit(hr_t), .blank(hr_tens_blank), .dash(hr_dash), .seg_c(seg5));

endmodule

// File: tb/tb_clock_display.sv
// Randomized self-checking bench for clock_display against an arithmetic display model.
module tb_clock_display;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  clock_display_if bus ();

  clock_display dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [6:0] E_BLANK = 7'h7F;
  localparam logic [6:0] E_DASH  = 7'h3F;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Active-low glyphs for decimal digits
  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return E_BLANK;
    endcase
  endfunction

  // Expected {HEX5..HEX0} for a given time and display mode
  function automatic logic [41:0] model_hex(input int s, input int m, input int h, input bit f);
    logic [6:0] d0, d1, d2, d3, d4, d5;
    int hd;
    if (s > 59) begin d0 = E_DASH; d1 = E_DASH; end
    else begin d0 = enc(s % 10); d1 = enc(s / 10); end
    if (m > 59) begin d2 = E_DASH; d3 = E_DASH; end
    else begin d2 = enc(m % 10); d3 = enc(m / 10); end
    if (h > 23) begin
      d4 = E_DASH; d5 = E_DASH;
    end else begin
      hd = h;
      if (f) hd = (h % 12 == 0) ? 12 : h % 12;
      d4 = enc(hd % 10);
      d5 = enc(hd / 10);
`ifdef CLOCK_DISPLAY_BLANK_LZ_EN
      if (hd / 10 == 0) d5 = E_BLANK;
`endif
    end
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  function automatic logic model_pm(input int h, input bit f);
    return f && (h >= 12);
  endfunction

  function automatic logic [41:0] dut_hex();
    return {bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  task automatic drive(input int s, input int m, input int h, input bit f);
    bus.sec     = 6'(s);
    bus.min     = 6'(m);
    bus.hr      = 5'(h);
    bus.fmt_12h = f;
  endtask

  // Steps past the capture edge, then until busy drops (bounded)
  task automatic wait_idle(output int cycles, output bit timeout);
    tick;
    cycles = 1;
    while (bus.busy && cycles < 100) begin
      tick;
      cycles++;
    end
    timeout = bus.busy;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 0, 0, 1'b0);
    tick;
    tick;
    checks++;
    if (dut_hex() !== {6{E_BLANK}}) begin
      failures++;
      $display("FAIL reset_hex got=%h exp=%h", dut_hex(), {6{E_BLANK}});
    end
    checks++;
    if ({bus.pm, bus.busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_pm_busy got=%b exp=00", {bus.pm, bus.busy});
    end
  endtask

  task automatic test_first_conversion;
    int n;
    rst = 1'b0;
    tick;
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick;
    end
    checks++;
    if (n !== 25) begin
      failures++;
      $display("FAIL first_busy_cycles got=%0d exp=25", n);
    end
    checks++;
    if (dut_hex() !== model_hex(0, 0, 0, 1'b0) || bus.pm !== 1'b0) begin
      failures++;
      $display("FAIL first_zero got=%h/%b exp=%h/0", dut_hex(), bus.pm, model_hex(0, 0, 0, 1'b0));
    end
  endtask

  task automatic test_formats;
    int cyc;
    bit to;
    int s, m, h;
    bit f;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin s = 59; m = 59; h = 23; f = 1'b0; end
        1: begin s = 59; m = 59; h = 23; f = 1'b1; end
        default: begin s = 59; m = 59; h = 0; f = 1'b1; end
      endcase
      drive(s, m, h, f);
      wait_idle(cyc, to);
      checks++;
      if (to || cyc !== 26) begin
        failures++;
        $display("FAIL fmt%0d_latency got=%0d timeout=%0b exp=26", k, cyc, to);
      end
      checks++;
      if (dut_hex() !== model_hex(s, m, h, f) || bus.pm !== model_pm(h, f)) begin
        failures++;
        $display("FAIL fmt%0d_value got=%h/%b exp=%h/%b", k, dut_hex(), bus.pm,
                 model_hex(s, m, h, f), model_pm(h, f));
      end
    end
  endtask

  task automatic test_out_of_range;
    int cyc;
    bit to;
    drive(60, 5, 24, 1'b0);
    wait_idle(cyc, to);
    checks++;
    if (to || dut_hex() !== {E_DASH, E_DASH, enc(0), enc(5), E_DASH, E_DASH}) begin
      failures++;
      $display("FAIL oor_dash got=%h exp=%h", dut_hex(),
               {E_DASH, E_DASH, enc(0), enc(5), E_DASH, E_DASH});
    end
  endtask

  task automatic test_leading_zero;
    int cyc;
    bit to;
    logic [6:0] exp5;
`ifdef CLOCK_DISPLAY_BLANK_LZ_EN
    exp5 = E_BLANK;
`else
    exp5 = enc(0);
`endif
    drive(12, 34, 7, 1'b0);
    wait_idle(cyc, to);
    checks++;
    if (to || bus.HEX5 !== exp5 || bus.HEX4 !== enc(7)) begin
      failures++;
      $display("FAIL hr_lz got=%h,%h exp=%h,%h", bus.HEX5, bus.HEX4, exp5, enc(7));
    end
  endtask

  task automatic test_random;
    int cyc;
    bit to;
    int s, m, h;
    bit f;
    for (int i = 0; i < 24; i++) begin
      s = int'($urandom_range(0, 63));
      m = int'($urandom_range(0, 63));
      h = int'($urandom_range(0, 31));
      f = 1'($urandom_range(0, 1));
      drive(s, m, h, f);
      wait_idle(cyc, to);
      checks++;
      if (to || dut_hex() !== model_hex(s, m, h, f) || bus.pm !== model_pm(h, f)) begin
        failures++;
        $display("FAIL rand%0d s=%0d m=%0d h=%0d f=%0b got=%h/%b exp=%h/%b", i, s, m, h, f,
                 dut_hex(), bus.pm, model_hex(s, m, h, f), model_pm(h, f));
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit to;
    logic [41:0] m9, m10, m11;
    m9  = model_hex(9, 30, 14, 1'b0);
    m10 = model_hex(10, 30, 14, 1'b0);
    m11 = model_hex(11, 30, 14, 1'b0);
    drive(9, 30, 14, 1'b0);
    wait_idle(cyc, to);
    drive(10, 30, 14, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick;
      checks++;
      if (dut_hex() !== m9) begin
        failures++;
        $display("FAIL b2b_early got=%h exp=%h", dut_hex(), m9);
      end
    end
    drive(11, 30, 14, 1'b0);
    cyc = 5;
    while (bus.busy && cyc < 100) begin
      tick;
      cyc++;
      if (dut_hex() !== m9 && dut_hex() !== m10) begin
        checks++;
        failures++;
        $display("FAIL b2b_tear got=%h exp=%h", dut_hex(), m10);
      end
    end
    checks++;
    if (bus.busy || dut_hex() !== m10) begin
      failures++;
      $display("FAIL b2b_first got=%h busy=%b exp=%h", dut_hex(), bus.busy, m10);
    end
    wait_idle(cyc, to);
    checks++;
    if (to || cyc !== 26 || dut_hex() !== m11) begin
      failures++;
      $display("FAIL b2b_second got=%h cyc=%0d exp=%h cyc=26", dut_hex(), cyc, m11);
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit to;
    drive(33, 44, 15, 1'b1);
    for (int c = 0; c < 12; c++) tick;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy_before got=%b exp=1", bus.busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (dut_hex() !== {6{E_BLANK}} || bus.busy !== 1'b0 || bus.pm !== 1'b0) begin
      failures++;
      $display("FAIL midrst_clear got=%h busy=%b pm=%b exp=%h busy=0 pm=0",
               dut_hex(), bus.busy, bus.pm, {6{E_BLANK}});
    end
    tick;
    tick;
    rst = 1'b0;
    wait_idle(cyc, to);
    checks++;
    if (to || cyc !== 26 || dut_hex() !== model_hex(33, 44, 15, 1'b1) || bus.pm !== 1'b1) begin
      failures++;
      $display("FAIL midrst_restart got=%h/%b cyc=%0d exp=%h/1 cyc=26", dut_hex(), bus.pm, cyc,
               model_hex(33, 44, 15, 1'b1));
    end
  endtask

  initial begin
    test_reset;
    test_first_conversion;
    test_formats;
    test_out_of_range;
    test_leading_zero;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
